// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, rs_val, rt_val, input busy, hi, lo);
   modport slave  (input start, op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with private HI/LO registers.
// Optional madd/maddu/msub/msubu support is enabled by defining MDU_MADD_EN.
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic          clk,
   input  logic          reset,
   mul_div_unit_if.slave md
);
   localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3,
                          OP_DIVU  = 4'd4, OP_MTHI  = 4'd5, OP_MTLO = 4'd6,
                          OP_MADD  = 4'd7, OP_MADDU = 4'd8, OP_MSUB = 4'd9,
                          OP_MSUBU = 4'd10;
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [63:0]   res_q, res_d;
   logic          wr_q, wr_d;

   // Result datapath evaluated on the issuing operands; captured at accept.
   logic        mul_signed, div_signed, neg_a, neg_b;
   logic [63:0] ext_a, ext_b, prod;
   logic [31:0] abs_a, abs_b, dvsr, uq, ur, quo, rem;

   always_comb begin
      mul_signed = (md.op == OP_MULT) || (md.op == OP_MADD) || (md.op == OP_MSUB);
      ext_a      = mul_signed ? {{32{md.rs_val[31]}}, md.rs_val} : {32'b0, md.rs_val};
      ext_b      = mul_signed ? {{32{md.rt_val[31]}}, md.rt_val} : {32'b0, md.rt_val};
      prod       = ext_a * ext_b;

      div_signed = (md.op == OP_DIV);
      neg_a      = div_signed & md.rs_val[31];
      neg_b      = div_signed & md.rt_val[31];
      abs_a      = neg_a ? -md.rs_val : md.rs_val;
      abs_b      = neg_b ? -md.rt_val : md.rt_val;
      // Zero divisor never commits; steer to 1 to keep the divider X-free.
      dvsr       = (md.rt_val == 32'd0) ? 32'd1 : abs_b;
      uq         = abs_a / dvsr;
      ur         = abs_a % dvsr;
      quo        = (neg_a ^ neg_b) ? -uq : uq;
      rem        = neg_a ? -ur : ur;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: begin
            if (md.start) begin
               case (md.op)
                  OP_MULT, OP_MULTU: begin
                     cnt_d   = CW'(MULT_CYCLES);
                     res_d   = prod;
                     wr_d    = 1'b1;
                     state_d = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     cnt_d   = CW'(DIV_CYCLES);
                     res_d   = {rem, quo};
                     wr_d    = (md.rt_val != 32'd0);
                     state_d = RUN;
                  end
                  OP_MTHI: hi_d = md.rs_val;
                  OP_MTLO: lo_d = md.rs_val;
`ifdef MDU_MADD_EN
                  OP_MADD, OP_MADDU: begin
                     cnt_d   = CW'(MULT_CYCLES);
                     res_d   = {hi_q, lo_q} + prod;
                     wr_d    = 1'b1;
                     state_d = RUN;
                  end
                  OP_MSUB, OP_MSUBU: begin
                     cnt_d   = CW'(MULT_CYCLES);
                     res_d   = {hi_q, lo_q} - prod;
                     wr_d    = 1'b1;
                     state_d = RUN;
                  end
`endif
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               if (wr_q) {hi_d, lo_d} = res_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         wr_q    <= wr_d;
      end
   end

   assign md.busy = (cnt_q != '0);
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;
endmodule
